// File: rtl/apb_slave_mux_pkg.sv
// Shared definitions for the APB slave mux: FSM states, the read data returned on
// an unmapped or timed-out access, and a constant-width helper.
package apb_slave_mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    localparam int unsigned MISS_RDATA = 0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_slave_mux_decoder.sv
// Combinational APB address decoder: splits the mapped window into 2**SLAVE_ADDR_BITS
// regions and reports the region index plus whether it lands on an existing slave.
module apb_addr_decoder #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    NUM_SLAVES      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int                    SLAVE_ADDR_BITS = 12,
    parameter int                    IDX_W           = 2
) (
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  hit_o
);

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] region;

    assign offset = paddr_i - BASE_ADDR;
    assign region = offset >> SLAVE_ADDR_BITS;
    assign idx_o  = region[IDX_W-1:0];
    // Below-base addresses would wrap the subtraction, so they are rejected first.
    assign hit_o  = (paddr_i >= BASE_ADDR) && (region < ADDR_WIDTH'(NUM_SLAVES));

endmodule

// File: rtl/apb_slave_mux.sv
// Fans one APB master port out to NUM_SLAVES peripherals; transfers take SETUP+ACCESS+wait states, response held until the master completes.
// Unmapped addresses answer PSLVERR after one cycle; define APB_SLAVE_MUX_TIMEOUT_EN to bound the ACCESS phase.
module apb_slave_mux
    import apb_slave_mux_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    NUM_SLAVES      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
    parameter int                    TIMEOUT_CYCLES  = 256,
`endif
    parameter int                    SLAVE_ADDR_BITS = 12
) (
    input  logic                             axi_aclk,
    input  logic                             axi_areset,
    input  logic                             s_psel,
    input  logic                             s_penable,
    input  logic                             s_pwrite,
    input  logic [ADDR_WIDTH-1:0]            s_paddr,
    input  logic [DATA_WIDTH-1:0]            s_pwdata,
    output logic [DATA_WIDTH-1:0]            s_prdata,
    output logic                             s_pready,
    output logic                             s_pslverr,
    output logic [NUM_SLAVES-1:0]            m_psel,
    output logic                             m_penable,
    output logic                             m_pwrite,
    output logic [ADDR_WIDTH-1:0]            m_paddr,
    output logic [DATA_WIDTH-1:0]            m_pwdata,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_prdata,
    input  logic [NUM_SLAVES-1:0]            m_pready,
    input  logic [NUM_SLAVES-1:0]            m_pslverr
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_SLAVES-1:0]   m_psel_q, m_psel_d;
    logic                    m_penable_q, m_penable_d;
    logic                    m_pwrite_q, m_pwrite_d;
    logic [ADDR_WIDTH-1:0]   m_paddr_q, m_paddr_d;
    logic [DATA_WIDTH-1:0]   m_pwdata_q, m_pwdata_d;
    logic [DATA_WIDTH-1:0]   s_prdata_q, s_prdata_d;
    logic                    s_pready_q, s_pready_d;
    logic                    s_pslverr_q, s_pslverr_d;

    logic [IDX_W-1:0]        dec_idx;
    logic                    dec_hit;
    logic [NUM_SLAVES-1:0]   sel_oh;
    logic [DATA_WIDTH-1:0]   slv_rdata;
    logic                    slv_ready;
    logic                    slv_err;

`ifdef APB_SLAVE_MUX_TIMEOUT_EN
    localparam int CNT_W = (clog2(TIMEOUT_CYCLES) > 0) ? clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    apb_addr_decoder #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .NUM_SLAVES      (NUM_SLAVES),
        .BASE_ADDR       (BASE_ADDR),
        .SLAVE_ADDR_BITS (SLAVE_ADDR_BITS),
        .IDX_W           (IDX_W)
    ) u_decoder (
        .paddr_i (s_paddr),
        .idx_o   (dec_idx),
        .hit_o   (dec_hit)
    );

    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_oh[i] = (idx_q == IDX_W'(i));
        end
    end

    assign slv_rdata = m_prdata[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign slv_ready = m_pready[idx_q];
    assign slv_err   = m_pslverr[idx_q];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        m_psel_d    = m_psel_q;
        m_penable_d = m_penable_q;
        m_pwrite_d  = m_pwrite_q;
        m_paddr_d   = m_paddr_q;
        m_pwdata_d  = m_pwdata_q;
        s_prdata_d  = s_prdata_q;
        s_pready_d  = s_pready_q;
        s_pslverr_d = s_pslverr_q;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                m_psel_d    = '0;
                m_penable_d = 1'b0;
                s_pready_d  = 1'b0;
                if (s_psel) begin
                    idx_d      = dec_idx;
                    m_pwrite_d = s_pwrite;
                    m_paddr_d  = s_paddr;
                    m_pwdata_d = s_pwdata;
                    if (dec_hit) begin
                        state_d = SETUP;
                    end else begin
                        state_d     = RESP;
                        s_prdata_d  = DATA_WIDTH'(MISS_RDATA);
                        s_pslverr_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                m_psel_d    = sel_oh;
                m_penable_d = 1'b0;
                state_d     = ACCESS;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
                cnt_d       = '0;
`endif
            end
            ACCESS: begin
                m_psel_d    = sel_oh;
                m_penable_d = 1'b1;
                // The slave only sees PENABLE once m_penable_q is up, so pready counts from then.
                if (m_penable_q && slv_ready) begin
                    m_psel_d    = '0;
                    m_penable_d = 1'b0;
                    s_prdata_d  = m_pwrite_q ? '0 : slv_rdata;
                    s_pslverr_d = slv_err;
                    s_pready_d  = 1'b1;
                    state_d     = RESP;
                end
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
                else if (m_penable_q) begin
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        m_psel_d    = '0;
                        m_penable_d = 1'b0;
                        s_prdata_d  = DATA_WIDTH'(MISS_RDATA);
                        s_pslverr_d = 1'b1;
                        s_pready_d  = 1'b1;
                        state_d     = RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
            end
            RESP: begin
                s_pready_d = 1'b1;
                if (!s_psel || (s_penable && s_pready_q)) begin
                    s_pready_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
            s_prdata_q  <= '0;
            s_pready_q  <= 1'b0;
            s_pslverr_q <= 1'b0;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            m_pwrite_q  <= m_pwrite_d;
            m_paddr_q   <= m_paddr_d;
            m_pwdata_q  <= m_pwdata_d;
            s_prdata_q  <= s_prdata_d;
            s_pready_q  <= s_pready_d;
            s_pslverr_q <= s_pslverr_d;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign m_psel    = m_psel_q;
    assign m_penable = m_penable_q;
    assign m_pwrite  = m_pwrite_q;
    assign m_paddr   = m_paddr_q;
    assign m_pwdata  = m_pwdata_q;
    assign s_prdata  = s_prdata_q;
    assign s_pready  = s_pready_q;
    assign s_pslverr = s_pslverr_q;

endmodule

// File: tb/tb_apb_slave_mux.sv
// Directed and randomized APB transfers through apb_slave_mux, checked against a
// transaction-level model of decode, latency and response.
module tb_apb_slave_mux;

    localparam int          NS   = 4;
    localparam int          DW   = 32;
    localparam int          AW   = 32;
    localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
    localparam int          TO   = 8;
`endif

    logic              axi_aclk, axi_areset;
    logic              s_psel, s_penable, s_pwrite;
    logic [AW-1:0]     s_paddr;
    logic [DW-1:0]     s_pwdata, s_prdata;
    logic              s_pready, s_pslverr;
    logic [NS-1:0]     m_psel;
    logic              m_penable, m_pwrite;
    logic [AW-1:0]     m_paddr;
    logic [DW-1:0]     m_pwdata;
    logic [NS*DW-1:0]  m_prdata;
    logic [NS-1:0]     m_pready, m_pslverr;

    int nvec = 0;
    int nerr = 0;

    apb_slave_mux #(
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
        .TIMEOUT_CYCLES (TO),
`endif
        .NUM_SLAVES     (NS)
    ) dut (
        .axi_aclk   (axi_aclk),
        .axi_areset (axi_areset),
        .s_psel     (s_psel),
        .s_penable  (s_penable),
        .s_pwrite   (s_pwrite),
        .s_paddr    (s_paddr),
        .s_pwdata   (s_pwdata),
        .s_prdata   (s_prdata),
        .s_pready   (s_pready),
        .s_pslverr  (s_pslverr),
        .m_psel     (m_psel),
        .m_penable  (m_penable),
        .m_pwrite   (m_pwrite),
        .m_paddr    (m_paddr),
        .m_pwdata   (m_pwdata),
        .m_prdata   (m_prdata),
        .m_pready   (m_pready),
        .m_pslverr  (m_pslverr)
    );

    initial begin
        axi_aclk = 1'b0;
        forever #5 axi_aclk = ~axi_aclk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_m_psel"},    m_psel,    0);
        chk({tag, "_m_penable"}, m_penable, 0);
        chk({tag, "_m_pwrite"},  m_pwrite,  0);
        chk({tag, "_m_paddr"},   m_paddr,   0);
        chk({tag, "_m_pwdata"},  m_pwdata,  0);
        chk({tag, "_s_prdata"},  s_prdata,  0);
        chk({tag, "_s_pready"},  s_pready,  0);
        chk({tag, "_s_pslverr"}, s_pslverr, 0);
    endtask

    task automatic idle();
        s_psel    = 1'b0;
        s_penable = 1'b0;
        @(posedge axi_aclk); #1;
    endtask

    // One upstream transfer; the target slave becomes ready after `waits` visible ACCESS cycles.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input int waits, input logic serr, input logic [31:0] srd);
        logic          hit;
        int            idx;
        logic [NS-1:0] oh;
        int            exp_lat, exp_pen;
        logic [31:0]   exp_rd;
        logic          exp_err;
        int            lat, pen, bad_sel, sel_at, pen_at;
        logic [31:0]   rd, seen_addr, seen_wd;
        logic          er, seen_wr;

        hit = (addr >= BASE) && ((addr - BASE) / 32'd4096 < 32'(NS));
        idx = hit ? int'((addr - BASE) / 32'd4096) : 0;
        oh  = hit ? (NS'(1) << idx) : '0;

        exp_lat = 1; exp_pen = 0; exp_err = 1'b1; exp_rd = 32'd0;
        if (hit) begin
            exp_lat = 3 + waits;
            exp_pen = waits + 1;
            exp_err = serr;
            exp_rd  = wr ? 32'd0 : srd;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
            if (waits >= TO) begin
                exp_lat = 2 + TO; exp_pen = TO; exp_err = 1'b1; exp_rd = 32'd0;
            end
`endif
        end

        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr; s_paddr = addr; s_pwdata = wd;
        for (int i = 0; i < NS; i++) begin
            m_prdata[i*DW +: DW] = $urandom;
            m_pslverr[i]         = 1'($urandom_range(0, 1));
            m_pready[i]          = 1'($urandom_range(0, 1));
        end
        if (hit) begin
            m_prdata[idx*DW +: DW] = srd;
            m_pslverr[idx]         = serr;
            m_pready[idx]          = 1'b0;
        end
        @(posedge axi_aclk); #1;
        s_penable = 1'b1;

        lat = -1; pen = 0; bad_sel = 0; sel_at = -1; pen_at = -1;
        rd = '0; er = 1'b0; seen_addr = '0; seen_wd = '0; seen_wr = 1'b0;
        for (int cyc = 1; cyc <= 1200; cyc++) begin
            @(posedge axi_aclk); #1;
            if (m_psel != 0 && m_psel !== oh) bad_sel++;
            if (m_psel != 0 && sel_at < 0) sel_at = cyc;
            if (m_psel != 0 && m_penable) begin
                if (pen_at < 0) pen_at = cyc;
                pen++;
                seen_addr = m_paddr; seen_wr = m_pwrite; seen_wd = m_pwdata;
            end
            if (s_pready) begin
                lat = cyc; rd = s_prdata; er = s_pslverr;
                break;
            end
            if (hit) m_pready[idx] = (pen > waits);
        end

        chk("latency", lat, exp_lat);
        chk("prdata", rd, exp_rd);
        chk("pslverr", er, exp_err);
        chk("psel_onehot", bad_sel, 0);
        chk("access_cycles", pen, exp_pen);
        if (hit) begin
            chk("psel_edge", sel_at, 1);
            chk("penable_edge", pen_at, 2);
            chk("slave_addr", seen_addr, addr);
            chk("slave_write", seen_wr, wr);
            chk("slave_wdata", seen_wd, wd);
        end

        @(posedge axi_aclk); #1;
        chk("pready_cleared", s_pready, 0);
        chk("psel_after", m_psel, 0);
        s_penable = 1'b0;
        if (hit) m_pready[idx] = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          r;

        axi_areset = 1'b1;
        s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = '0; s_pwdata = '0;
        m_prdata = '0; m_pready = '0; m_pslverr = '0;
        repeat (3) @(posedge axi_aclk);
        #1;
        chk_zero("reset");
        axi_areset = 1'b0;

        xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
        idle();
        xfer(32'h0000_3010, 1'b0, 32'h0, 4, 1'b0, 32'h1234_5678);
        idle();
        xfer(32'h0000_4000, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        idle();
        xfer(32'h0000_0040, 1'b1, 32'hCAFE_0001, 1, 1'b1, 32'h0);
        xfer(32'h0000_0044, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_A5A5);
        idle();
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
        xfer(32'h0000_2008, 1'b0, 32'h0, 100000, 1'b0, 32'h55);
        idle();
`endif

        // Upstream abandons a pending error response.
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = 32'h0001_0000;
        @(posedge axi_aclk); #1;
        s_penable = 1'b1;
        @(posedge axi_aclk); #1;
        chk("abort_pready", s_pready, 1);
        s_psel = 1'b0; s_penable = 1'b0;
        @(posedge axi_aclk); #1;
        chk("abort_cleared", s_pready, 0);
        @(posedge axi_aclk); #1;
        chk("abort_idle", s_pready, 0);

        // Stalled slave 2, then reset in the middle of ACCESS.
        s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b1; s_paddr = 32'h0000_2008; s_pwdata = 32'h77;
        m_pready = '0;
        @(posedge axi_aclk); #1;
        s_penable = 1'b1;
`ifdef APB_SLAVE_MUX_TIMEOUT_EN
        repeat (5) @(posedge axi_aclk);
`else
        repeat (1000) @(posedge axi_aclk);
`endif
        #1;
        chk("stall_psel", m_psel, 4'b0100);
        chk("stall_penable", m_penable, 1);
        chk("stall_pready", s_pready, 0);
        axi_areset = 1'b1;
        @(posedge axi_aclk); #1;
        chk_zero("mid_reset");
        axi_areset = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
        @(posedge axi_aclk); #1;
        xfer(32'h0000_2000, 1'b1, 32'h0BAD_F00D, 2, 1'b0, 32'h0);
        idle();

        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(0, 5));
            a = (r == 5) ? $urandom : ((32'(r) << 12) | ($urandom & 32'h0000_0FFC));
            xfer(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 1) == 1) idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/apb_slave_mux.md
Name: apb_slave_mux

Overview:
- Downstream stage of the AXI-to-APB bridge: accepts one upstream APB master port and fans it out to NUM_SLAVES APB peripherals.
- Decodes the address into a slave index and re-times the transfer as a clean SETUP/ACCESS sequence on the selected slave.
- Returns read data and the slave response upstream; unmapped addresses and stalled slaves complete with PSLVERR.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- NUM_SLAVES, 4, number of downstream slaves (1..16).
- BASE_ADDR, 32'h0000_0000, start of the mapped window.
- SLAVE_ADDR_BITS, 12, log2 of the region size per slave (4 KiB each).
- TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit (only with the optional feature).

Ports:
- axi_aclk  in  1  clock
- axi_areset  in  1  reset, synchronous, active-high
- s_psel / s_penable / s_pwrite  in  1 each  upstream APB controls
- s_paddr  in  ADDR_WIDTH  upstream address
- s_pwdata  in  DATA_WIDTH  upstream write data
- s_prdata  out  DATA_WIDTH  upstream read data (registered)
- s_pready  out  1  upstream ready (registered)
- s_pslverr  out  1  upstream error (registered)
- m_psel  out  NUM_SLAVES  one-hot slave selects
- m_penable / m_pwrite  out  1 each  downstream controls
- m_paddr  out  ADDR_WIDTH  full latched address
- m_pwdata  out  DATA_WIDTH  latched write data
- m_prdata  in  NUM_SLAVES*DATA_WIDTH  slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- m_pready / m_pslverr  in  NUM_SLAVES each  per-slave ready and error

Behaviour:
- Reset behaviour: one clock, axi_aclk. Reset is synchronous and active-high (axi_areset). While reset is sampled high:
  - state goes to IDLE;
  - every output is driven to 0: m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, s_prdata, s_pready, s_pslverr;
  - the timeout counter is cleared.
  - Reset mid-transfer drops m_psel at the next edge, and the transfer is lost without a response.
- Address decode: off = s_paddr - BASE_ADDR; idx = off >> SLAVE_ADDR_BITS.
  - hit = (s_paddr >= BASE_ADDR) && (idx < NUM_SLAVES), with no wrap past the top of the address space.
- IDLE:
  - On s_psel=1, latch s_paddr, s_pwrite, s_pwdata and idx.
  - hit goes to SETUP; miss goes to RESP with err=1 and rdata=0.
  - s_penable is not required in IDLE.
- SETUP: m_psel[idx]=1, m_penable=0, address/write/data driven from the latches. Unconditionally go to ACCESS.
- ACCESS:
  - m_psel[idx]=1, m_penable=1.
  - Only m_pready[idx] is sampled; other slaves' pready/pslverr are ignored.
  - On m_pready[idx]=1: capture m_prdata slice and m_pslverr[idx] (rdata forced to 0 on writes), drop m_psel and m_penable next edge, go to RESP.
- RESP:
  - s_pready=1 with the captured s_prdata and s_pslverr, held until s_psel && s_penable is sampled; then go to IDLE and clear s_pready.
  - If s_psel drops while in RESP (upstream abort), go to IDLE silently.
- Latency: with the slave's pready tied high, s_psel sampled at edge 0 gives m_psel at 1, m_penable at 2, and s_pready at 3.
- Back-to-back transfers: one IDLE cycle is mandatory between transfers; s_psel held high after completion starts a new transfer.
- m_paddr and m_pwdata hold their last values in IDLE; only m_psel/m_penable qualify them.
- Exactly one m_psel bit is ever high; none is high in IDLE or RESP.

Optional Feature:
- APB_SLAVE_MUX_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYCLES) clears on entering ACCESS and increments each ACCESS cycle without m_pready[idx].
  - When it reaches TIMEOUT_CYCLES-1 and pready is still low, drop m_psel/m_penable and go to RESP with s_pslverr=1, s_prdata=0.
  - m_pready arriving on that same cycle wins: the transfer completes normally.
- Undefined: no counter is implemented and ACCESS waits indefinitely.

Decomposition:
- apb_slave_mux_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - localparam for the PSLVERR-on-miss rdata value (0);
  - clog2 helper function.
- Sub-module apb_addr_decoder: combinational paddr -> idx and hit. Kept separate so it can be reused by other fabrics.

Test Plan:
- Write 0x0000_1004 data 0xDEADBEEF, slave 1 pready tied high -> m_psel=4'b0010 at edge 1, m_penable at edge 2, s_pready at edge 3; s_pslverr=0; slave 1 sees addr 0x1004 and data 0xDEADBEEF.
- Read 0x0000_3010, slave 3 inserts 4 wait states and returns 0x12345678 -> s_prdata=0x12345678 with s_pready at edge 7; other m_psel bits stay 0 throughout.
- Read 0x0000_4000 (unmapped, NUM_SLAVES=4) -> no m_psel; s_pready=1, s_pslverr=1, s_prdata=0 at edge 1.
- With the macro defined, TIMEOUT_CYCLES=8, slave 2 never ready -> m_psel[2] drops after 8 ACCESS cycles; s_pslverr=1, s_prdata=0. Without the macro -> still in ACCESS after 1000 cycles.
- Slave 0 returns pslverr=1 on a write -> s_pslverr=1 propagated. The next back-to-back read to slave 0 completes with s_pslverr=0.
- axi_areset asserted during ACCESS -> all outputs 0 at the next edge. A subsequent write to 0x0000_2000 completes normally.
